// File: rtl/la_iodeglitch.sv
// Pad input deglitcher: synchronizer chain, threshold-qualified level filter,
// edge pulses and a saturating count of rejected glitches.
module la_iodeglitch #(
   parameter int unsigned SYNCW = 2,
   parameter int unsigned CNTW  = 8,
   parameter int unsigned GCW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in,
   input  logic            en,
   input  logic [CNTW-1:0] thresh,
   input  logic            gclr,
   output logic            out,
   output logic            rise,
   output logic            fall,
   output logic            pending,
   output logic [GCW-1:0]  gcnt
);

   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [SYNCW-1:0]  sync_q;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              out_d, rise_d, fall_d;
   logic [GCW-1:0]    gcnt_d;
   logic              glitch;
   logic              s;

   assign s = sync_q[SYNCW-1];

   // Synchronizer runs independently of the filter enable
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNCW-2:0], in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         out     <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
         pending <= 1'b0;
         gcnt    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out     <= out_d;
         rise    <= rise_d;
         fall    <= fall_d;
         pending <= (state_d == PENDING);
         gcnt    <= gcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      glitch  = 1'b0;
      gcnt_d  = gcnt;

      if (!en) begin
         // Disabled: drop any qualification silently
         state_d = STABLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            STABLE: begin
               if (s != out) begin
                  if (thresh == '0) begin
                     out_d  = s;
                     rise_d = s;
                     fall_d = ~s;
                  end else begin
                     state_d = PENDING;
                     cnt_d   = CNTW'(1);
                  end
               end
            end
            PENDING: begin
               if (s == out) begin
                  state_d = STABLE;
                  cnt_d   = '0;
                  glitch  = 1'b1;
               end else if (cnt_q >= thresh) begin
                  // >= lets a lowered threshold accept immediately
                  out_d   = s;
                  rise_d  = s;
                  fall_d  = ~s;
                  state_d = STABLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            default: begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (gclr)                        gcnt_d = '0;
      else if (glitch && (gcnt != '1)) gcnt_d = gcnt + GCW'(1);
   end

endmodule

// File: tb/tb_la_iodeglitch.sv
// Self-checking bench for la_iodeglitch: directed scenarios plus random
// stimulus compared against a run-length reference model.
module tb_la_iodeglitch;

   localparam int unsigned SYNCW = 2;
   localparam int unsigned CNTW  = 8;
   localparam int unsigned GCW   = 8;
   localparam int          GMAX  = (1 << GCW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in = 1'b0;
   logic            en = 1'b1;
   logic [CNTW-1:0] thresh = CNTW'(3);
   logic            gclr = 1'b0;
   logic            out_w, rise_w, fall_w, pend_w;
   logic [GCW-1:0]  gcnt_w;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: delay line of samples and length of the
   // current run of consecutive enabled samples that differ from out.
   bit sq[$];
   int run = 0;
   bit m_out = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_pend = 1'b0;
   int m_gcnt = 0;

   la_iodeglitch #(.SYNCW(SYNCW), .CNTW(CNTW), .GCW(GCW)) dut (
      .clk(clk), .rst(rst), .in(in), .en(en), .thresh(thresh), .gclr(gclr),
      .out(out_w), .rise(rise_w), .fall(fall_w), .pending(pend_w), .gcnt(gcnt_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit sv;
      sv = sq[0];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
         for (int i = 0; i < int'(SYNCW); i++) sq[i] = 1'b0;
         run = 0; m_out = 1'b0; m_gcnt = 0;
      end else begin
         void'(sq.pop_front());
         sq.push_back(in);
         if (!en) run = 0;
         else if (sv != m_out) begin
            run++;
            if (run >= int'(thresh) + 1) begin
               m_out = sv; m_rise = sv; m_fall = ~sv; run = 0;
            end
         end else begin
            if (run > 0 && m_gcnt < GMAX) m_gcnt++;
            run = 0;
         end
         if (gclr) m_gcnt = 0;
      end
      m_pend = (run > 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("out",     int'(out_w),  int'(m_out));
      check("rise",    int'(rise_w), int'(m_rise));
      check("fall",    int'(fall_w), int'(m_fall));
      check("pending", int'(pend_w), int'(m_pend));
      check("gcnt",    int'(gcnt_w), m_gcnt);
   endtask

   task automatic glitch1();
      in = 1'b1; step();
      in = 1'b0;
      for (int i = 0; i < 4; i++) step();
   endtask

   int k;
   int hold;

   initial begin
      for (int i = 0; i < int'(SYNCW); i++) sq.push_back(1'b0);

      // reset state
      rst = 1'b1; step(); step();
      rst = 1'b0; step(); step();

      // basic latency: 0->1 with thresh=3 accepts on the 6th edge
      thresh = CNTW'(3);
      in = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (out_w === 1'b1) begin k = i; break; end
      end
      check("latency", k, 6);
      for (int i = 0; i < 4; i++) step();

      // falling edge, then a 2-cycle glitch that must be rejected
      in = 1'b0;
      for (int i = 0; i < 8; i++) step();
      in = 1'b1; step(); step();
      in = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("glitch_cnt", int'(gcnt_w), 1);

      // thresh=0: out follows in after SYNCW+1 edges
      thresh = '0;
      for (int i = 0; i < 12; i++) begin
         in = ~in; step(); step();
      end
      in = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // saturate the glitch counter with single-sample glitches
      thresh = CNTW'(1);
      for (int i = 0; i < GMAX + 5; i++) glitch1();
      check("gcnt_sat", int'(gcnt_w), GMAX);

      // clear coincident with an abort: clear wins
      in = 1'b1; step();
      in = 1'b0; step(); step();
      gclr = 1'b1; step();
      gclr = 1'b0;
      check("gclr_win", int'(gcnt_w), 0);
      step(); step();

      // reset while pending with cnt=2
      thresh = CNTW'(3);
      in = 1'b1;
      for (int i = 0; i < 20 && run != 2; i++) step();
      rst = 1'b1; step();
      rst = 1'b0;
      check("rst_pend", int'(pend_w), 0);
      for (int i = 0; i < 10; i++) step();
      in = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // enable dropped mid-qualification, then restored with in still high
      in = 1'b1;
      for (int i = 0; i < 20 && run != 2; i++) step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) step();
      en = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (out_w === 1'b1) begin k = i; break; end
      end
      check("en_restore", k, int'(thresh) + 1);

      // threshold lowered below cnt mid-qualification
      in = 1'b0;
      thresh = CNTW'(4);
      for (int i = 0; i < 5; i++) step();
      thresh = CNTW'(1);
      step(); step();
      thresh = CNTW'(3);
      for (int i = 0; i < 6; i++) step();

      // randomized traffic
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            in   = 1'($urandom);
            hold = int'($urandom_range(1, 7));
         end
         hold--;
         en   = ($urandom_range(0, 19) != 0);
         gclr = ($urandom_range(0, 49) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) == 0) thresh = CNTW'($urandom_range(0, 4));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
